// File: rtl/capture_controller_if.sv
// Pixel-write, host-read and frame-buffer RAM signals of the capture controller.
// master: the capture controller itself; slave: the demosaic/host/RAM side.
interface capture_controller_if #(
    parameter int unsigned ADDR_W = 18
);
    logic              px_wr_en;
    logic [ADDR_W-1:0] px_addr;
    logic [7:0]        px_data;
    logic              demosaic_en;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [7:0]        rd_data;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;

    modport master (
        input  px_wr_en, px_addr, px_data, rd_req, rd_addr, ram_rdata,
        output demosaic_en, rd_valid, rd_data, ram_en, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        output px_wr_en, px_addr, px_data, rd_req, rd_addr, ram_rdata,
        input  demosaic_en, rd_valid, rd_data, ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/capture_controller.sv
// One-shot frame capture sequencer and frame-buffer RAM arbiter.
// Arms on capture_req, waits for a clean fv rising edge, admits exactly one
// frame of demosaic writes, then hands the RAM to the host reader.
// Optional macro CAPTURE_CHECKSUM_EN: 16-bit running sum of accepted pixels;
// without it the checksum output is tied to zero.
module capture_controller #(
    parameter int unsigned ADDR_W         = 18,
    parameter int unsigned FRAME_PIXELS   = 160000,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  capture_req,
    input  logic                  capture_abort,
    input  logic                  fv,
    capture_controller_if.master  bus,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_W-1:0]     pixel_count,
    output logic [15:0]           checksum
);
    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_WAIT_FV_LOW  = 3'd1,
        S_WAIT_FV_HIGH = 3'd2,
        S_CAPTURE      = 3'd3,
        S_READOUT      = 3'd4,
        S_ERROR        = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] FRAME_MAX = ADDR_W'(FRAME_PIXELS);
    localparam logic [ADDR_W-1:0] CNT_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic              fv_meta_q, fv_s_q, fv_prev_q;
    logic [23:0]       tmo_q, tmo_d;
    logic              demosaic_en_q, demosaic_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [ADDR_W-1:0] pixel_count_q, pixel_count_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        ram_wdata_q, ram_wdata_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_valid_q;
    logic              arm_s;
    logic              fv_rise_s, fv_fall_s, tmo_hit_s;
`ifdef CAPTURE_CHECKSUM_EN
    logic [15:0]       csum_q, csum_d;
`endif

    assign fv_rise_s = fv_s_q & ~fv_prev_q;
    assign fv_fall_s = ~fv_s_q & fv_prev_q;
    assign tmo_hit_s = (tmo_q == (TIMEOUT_CYCLES - 24'd1));

    // State register of the capture sequencer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and next-output decode; abort overrides everything else.
    always_comb begin
        state_d       = state_q;
        arm_s         = 1'b0;
        demosaic_en_d = demosaic_en_q;
        done_d        = done_q;
        error_d       = error_q;
        pixel_count_d = pixel_count_q;
        ram_en_d      = 1'b0;
        ram_we_d      = 1'b0;
        ram_addr_d    = ram_addr_q;
        ram_wdata_d   = ram_wdata_q;
        rd_pend_d     = 1'b0;
`ifdef CAPTURE_CHECKSUM_EN
        csum_d        = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (capture_req) arm_s = 1'b1;
                else             arm_s = 1'b0;
            end
            S_WAIT_FV_LOW: begin
                // Waiting for fv low rejects a frame that is already running.
                if (!fv_s_q)        state_d = S_WAIT_FV_HIGH;
                else if (tmo_hit_s) state_d = S_ERROR;
                else                state_d = state_q;
            end
            S_WAIT_FV_HIGH: begin
                if (fv_rise_s) begin
                    state_d       = S_CAPTURE;
                    demosaic_en_d = 1'b1;
                end else if (tmo_hit_s) begin
                    state_d       = S_ERROR;
                    demosaic_en_d = 1'b0;
                end else begin
                    state_d       = state_q;
                end
            end
            S_CAPTURE: begin
                if (bus.px_wr_en && (pixel_count_q < FRAME_MAX)) begin
                    ram_en_d      = 1'b1;
                    ram_we_d      = 1'b1;
                    ram_addr_d    = bus.px_addr;
                    ram_wdata_d   = bus.px_data;
                    pixel_count_d = pixel_count_q + CNT_ONE;
`ifdef CAPTURE_CHECKSUM_EN
                    csum_d        = csum_q + {8'd0, bus.px_data};
`endif
                end else begin
                    pixel_count_d = pixel_count_q;
                end
                // A write landing on the falling-edge cycle still counts.
                if (fv_fall_s) begin
                    demosaic_en_d = 1'b0;
                    if (pixel_count_d == FRAME_MAX) begin
                        state_d = S_READOUT;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERROR;
                    end
                end else if (tmo_hit_s) begin
                    state_d       = S_ERROR;
                    demosaic_en_d = 1'b0;
                end else begin
                    state_d       = state_q;
                end
            end
            S_READOUT: begin
                if (bus.rd_req) begin
                    ram_en_d   = 1'b1;
                    ram_we_d   = 1'b0;
                    ram_addr_d = bus.rd_addr;
                    rd_pend_d  = 1'b1;
                end else begin
                    rd_pend_d  = 1'b0;
                end
                if (capture_req) arm_s = 1'b1;
                else             arm_s = 1'b0;
            end
            S_ERROR: begin
                error_d = 1'b1;
                if (capture_req) arm_s = 1'b1;
                else             arm_s = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (arm_s) begin
            state_d       = S_WAIT_FV_LOW;
            pixel_count_d = {ADDR_W{1'b0}};
            done_d        = 1'b0;
            error_d       = 1'b0;
`ifdef CAPTURE_CHECKSUM_EN
            csum_d        = 16'd0;
`endif
        end else if (state_d == S_ERROR) begin
            error_d = 1'b1;
        end else begin
            error_d = error_d;
        end

        if (capture_abort) begin
            state_d       = S_IDLE;
            demosaic_en_d = 1'b0;
            done_d        = 1'b0;
            error_d       = error_q;
            pixel_count_d = pixel_count_q;
            ram_en_d      = 1'b0;
            ram_we_d      = 1'b0;
            rd_pend_d     = 1'b0;
`ifdef CAPTURE_CHECKSUM_EN
            csum_d        = csum_q;
`endif
        end else begin
            state_d = state_d;
        end

        busy_d = (state_d == S_WAIT_FV_LOW) || (state_d == S_WAIT_FV_HIGH) ||
                 (state_d == S_CAPTURE);

        // Timeout restarts on every state change and only runs while busy.
        if (state_d != state_q) tmo_d = 24'd0;
        else if (busy_d)        tmo_d = tmo_q + 24'd1;
        else                    tmo_d = 24'd0;
    end

    // fv synchroniser, edge reference, timeout, registered outputs and read pipe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fv_meta_q     <= 1'b0;
            fv_s_q        <= 1'b0;
            fv_prev_q     <= 1'b0;
            tmo_q         <= 24'd0;
            demosaic_en_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            pixel_count_q <= {ADDR_W{1'b0}};
            ram_en_q      <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= {ADDR_W{1'b0}};
            ram_wdata_q   <= 8'd0;
            rd_pend_q     <= 1'b0;
            rd_valid_q    <= 1'b0;
        end else begin
            fv_meta_q     <= fv;
            fv_s_q        <= fv_meta_q;
            fv_prev_q     <= fv_s_q;
            tmo_q         <= tmo_d;
            demosaic_en_q <= demosaic_en_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
            pixel_count_q <= pixel_count_d;
            ram_en_q      <= ram_en_d;
            ram_we_q      <= ram_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
            rd_pend_q     <= rd_pend_d;
            rd_valid_q    <= rd_pend_q;
        end
    end

`ifdef CAPTURE_CHECKSUM_EN
    // Running modulo-2^16 pixel sum, cleared on arm and held after capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csum_q <= 16'd0;
        end else begin
            csum_q <= csum_d;
        end
    end
    assign checksum = csum_q;
`else
    assign checksum = 16'd0;
`endif

    assign bus.demosaic_en = demosaic_en_q;
    assign bus.ram_en      = ram_en_q;
    assign bus.ram_we      = ram_we_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_wdata   = ram_wdata_q;
    assign bus.rd_valid    = rd_valid_q;
    // RAM output is registered inside the RAM, so it is gated, not re-registered.
    assign bus.rd_data     = rd_valid_q ? bus.ram_rdata : 8'd0;
    assign busy            = busy_q;
    assign done            = done_q;
    assign error           = error_q;
    assign pixel_count     = pixel_count_q;
endmodule

// File: tb/tb_capture_controller.sv
// Randomised bench for capture_controller with a small frame and short timeout.
module tb_capture_controller;
    localparam int unsigned AW = 18;
    localparam int unsigned FP = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          capture_req = 1'b0;
    logic          capture_abort = 1'b0;
    logic          fv = 1'b0;
    logic          busy, done, error;
    logic [AW-1:0] pixel_count;
    logic [15:0]   checksum;

    int total = 0;
    int bad = 0;
    int we_cnt = 0;
    int rv_cnt = 0;
    logic [7:0] mem [0:255];
    logic [7:0] exp_mem [0:255];

    capture_controller_if #(.ADDR_W(AW)) bus ();

    capture_controller #(
        .ADDR_W(AW), .FRAME_PIXELS(FP), .TIMEOUT_CYCLES(24'd100)
    ) dut (
        .clk(clk), .reset_n(reset_n), .capture_req(capture_req),
        .capture_abort(capture_abort), .fv(fv), .bus(bus), .busy(busy),
        .done(done), .error(error), .pixel_count(pixel_count), .checksum(checksum)
    );

    always #5 clk = ~clk;

    // Single-port RAM, 1-cycle read latency; also counts write pulses.
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) begin
                mem[bus.ram_addr[7:0]] <= bus.ram_wdata;
                we_cnt <= we_cnt + 1;
            end else begin
                bus.ram_rdata <= mem[bus.ram_addr[7:0]];
            end
        end
    end

    // Count every cycle rd_valid is high.
    always @(posedge clk) begin
        if (bus.rd_valid) rv_cnt <= rv_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_req();
        capture_req = 1'b1;
        step();
        capture_req = 1'b0;
    endtask

    // Capture one frame of n writes; model decides accepted count, done/error, checksum.
    task automatic run_frame(input int n, input bit seq_data, input bit fv_high_first);
        logic [7:0] data [0:31];
        int exp_cnt, exp_sum, we0, rv0;
        exp_cnt = (n < FP) ? n : FP;
        exp_sum = 0;
        for (int i = 0; i < n; i++) begin
            data[i] = seq_data ? 8'(i + 1) : 8'($urandom_range(0, 255));
            if (i < exp_cnt) begin
                exp_sum = (exp_sum + data[i]) % 65536;
                exp_mem[i] = data[i];
            end
        end
`ifndef CAPTURE_CHECKSUM_EN
        exp_sum = 0;
`endif
        we0 = we_cnt;
        rv0 = rv_cnt;
        if (fv_high_first) begin
            fv = 1'b1;
            step(4);
        end
        pulse_req();
        step(2);
        check("arm_busy", busy, 1);
        check("arm_err_clr", error, 0);
        check("arm_done_clr", done, 0);
        check("arm_den", bus.demosaic_en, 0);
        if (fv_high_first) begin
            for (int i = 0; i < 5; i++) begin
                bus.px_wr_en = 1'b1;
                bus.px_addr  = 18'(200 + i);
                bus.px_data  = 8'hAA;
                step();
            end
            bus.px_wr_en = 1'b0;
            step(2);
            check("partial_no_we", we_cnt - we0, 0);
            fv = 1'b0;
            step(5);
        end else begin
            step(3);
        end
        check("den_before_rise", bus.demosaic_en, 0);
        fv = 1'b1;
        step(5);
        check("den_in_frame", bus.demosaic_en, 1);
        for (int i = 0; i < n; i++) begin
            bus.px_wr_en = 1'b1;
            bus.px_addr  = 18'(i);
            bus.px_data  = data[i];
            bus.rd_req   = 1'($urandom_range(0, 1));
            bus.rd_addr  = 18'(i);
            step();
        end
        bus.px_wr_en = 1'b0;
        bus.rd_req   = 1'b0;
        step(2);
        check("we_pulses", we_cnt - we0, exp_cnt);
        check("pixel_count", pixel_count, exp_cnt);
        fv = 1'b0;
        step(6);
        check("den_after_fall", bus.demosaic_en, 0);
        check("done", done, (n >= FP) ? 1 : 0);
        check("error", error, (n < FP) ? 1 : 0);
        check("busy_after", busy, 0);
        check("checksum", checksum, exp_sum);
        check("no_rd_in_capture", rv_cnt - rv0, 0);
    endtask

    // Three back-to-back reads; data must appear exactly two cycles after each request.
    task automatic readout(input int a0, input int a1, input int a2);
        int addrs [0:2];
        addrs[0] = a0; addrs[1] = a1; addrs[2] = a2;
        for (int c = 0; c < 7; c++) begin
            bus.rd_req  = (c < 3) ? 1'b1 : 1'b0;
            bus.rd_addr = (c < 3) ? 18'(addrs[c]) : 18'd0;
            step();
            bus.rd_req = 1'b0;
            check("rd_valid", bus.rd_valid, (c >= 1 && c <= 3) ? 1 : 0);
            if (c >= 1 && c <= 3) check("rd_data", bus.rd_data, exp_mem[addrs[c - 1]]);
        end
    endtask

    initial begin
        int cyc, n;
        bus.px_wr_en = 1'b0; bus.px_addr = '0; bus.px_data = 8'd0;
        bus.rd_req = 1'b0; bus.rd_addr = '0; bus.ram_rdata = 8'd0;
        step(2);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_pc", pixel_count, 0);
        check("rst_csum", checksum, 0);
        check("rst_den", bus.demosaic_en, 0);
        check("rst_ram_en", bus.ram_en, 0);
        check("rst_ram_we", bus.ram_we, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        reset_n = 1'b1;
        step(3);

        run_frame(16, 1'b1, 1'b0);
        readout(0, 1, 2);
        run_frame(12, 1'b0, 1'b0);
        run_frame(20, 1'b0, 1'b1);
        readout($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
        for (int k = 0; k < 3; k++) begin
            n = $urandom_range(10, 22);
            run_frame(n, 1'b0, 1'($urandom_range(0, 1)));
            if (n >= FP) readout($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
        end

        // Abort in the middle of a capture.
        pulse_req();
        step(3);
        fv = 1'b1;
        step(5);
        check("pre_abort_den", bus.demosaic_en, 1);
        capture_abort = 1'b1;
        step();
        capture_abort = 1'b0;
        check("abort_den", bus.demosaic_en, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        fv = 1'b0;
        step(4);
        // Abort and request together: abort wins, stays idle.
        capture_req = 1'b1;
        capture_abort = 1'b1;
        step();
        capture_req = 1'b0;
        capture_abort = 1'b0;
        step(2);
        check("abort_wins", busy, 0);

        // Timeout with fv held low.
        pulse_req();
        cyc = 0;
        while (!error && cyc < 400) begin
            step();
            cyc++;
            if (cyc == 90) check("no_early_timeout", error, 0);
        end
        check("timeout_window", (cyc >= 95 && cyc <= 105) ? 1 : 0, 1);
        check("timeout_busy", busy, 0);
        capture_abort = 1'b1;
        step();
        capture_abort = 1'b0;
        check("abort_keeps_error", error, 1);

        // Asynchronous reset mid-capture.
        pulse_req();
        step(3);
        fv = 1'b1;
        step(5);
        bus.px_wr_en = 1'b1;
        bus.px_data  = 8'h55;
        step(3);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_den", bus.demosaic_en, 0);
        check("arst_busy", busy, 0);
        check("arst_pc", pixel_count, 0);
        check("arst_ram_we", bus.ram_we, 0);
        check("arst_error", error, 0);
        bus.px_wr_en = 1'b0;
        fv = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(2);
        check("post_rst_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
